// File: rtl/alu_wb_stage.sv
// Execute-to-writeback stage: registers ALU results into a 2-entry writeback FIFO
// and maintains the architectural compare flags and the sticky overflow flag.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif
`ifndef ADD
`define ADD 5'd0
`endif
`ifndef SUB
`define SUB 5'd1
`endif
`ifndef CMP
`define CMP 5'd2
`endif

module alu_wb_stage #(
    parameter int DATA_W = `WORD_SIZE,
    parameter int RD_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        opcode,
    input  logic [RD_W-1:0]   rd,
    input  logic [DATA_W-1:0] alu_c,
    input  logic              alu_overflow,
    input  logic [1:0]        alu_comp_flag,
    input  logic              trap_en,
    input  logic              flag_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RD_W-1:0]   out_rd,
    output logic [DATA_W-1:0] out_data,
    output logic              cmp_eq,
    output logic              cmp_gt,
    output logic              ovf_sticky,
    output logic              ovf_trap
);

    localparam int ENTRY_W = RD_W + DATA_W;

    logic [ENTRY_W-1:0] mem_q [2];
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [1:0]         count_q, count_d;
    logic               cmp_eq_q, cmp_eq_d;
    logic               cmp_gt_q, cmp_gt_d;
    logic               sticky_q, sticky_d;
    logic               trap_q, trap_d;

    logic acc, pop, push, is_addsub, is_cmp, ovf_hit, trap_hit;

    // Overflow and compare inputs are only meaningful for their own opcodes,
    // so they are masked by the decoded accept before touching any state.
    always_comb begin
        acc       = in_valid & in_ready;
        pop       = out_valid & out_ready;
        is_addsub = acc & ((opcode == `ADD) | (opcode == `SUB));
        is_cmp    = acc & (opcode == `CMP);
        ovf_hit   = is_addsub & alu_overflow;
        trap_hit  = ovf_hit & trap_en;
        push      = is_addsub & ~trap_hit;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        cmp_eq_d = cmp_eq_q;
        cmp_gt_d = cmp_gt_q;
        sticky_d = sticky_q;
        trap_d   = trap_hit;
        if (push) wr_ptr_d = ~wr_ptr_q;
        if (pop)  rd_ptr_d = ~rd_ptr_q;
        count_d = count_q + {1'b0, push} - {1'b0, pop};
        if (is_cmp) begin
            cmp_eq_d = alu_comp_flag[0];
            cmp_gt_d = alu_comp_flag[1];
        end
        // A setting overflow beats a same-cycle clear.
        if (ovf_hit)       sticky_d = 1'b1;
        else if (flag_clr) sticky_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            cmp_eq_q <= 1'b0;
            cmp_gt_q <= 1'b0;
            sticky_q <= 1'b0;
            trap_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cmp_eq_q <= cmp_eq_d;
            cmp_gt_q <= cmp_gt_d;
            sticky_q <= sticky_d;
            trap_q   <= trap_d;
        end
    end

    // Payload storage needs no reset; it is only observed while out_valid is high.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {rd, alu_c};
    end

    assign in_ready   = (count_q < 2'd2);
    assign out_valid  = (count_q != 2'd0);
    assign out_rd     = mem_q[rd_ptr_q][ENTRY_W-1:DATA_W];
    assign out_data   = mem_q[rd_ptr_q][DATA_W-1:0];
    assign cmp_eq     = cmp_eq_q;
    assign cmp_gt     = cmp_gt_q;
    assign ovf_sticky = sticky_q;
    assign ovf_trap   = trap_q;

endmodule

// File: tb/tb_alu_wb_stage.sv
// Bench for alu_wb_stage: directed scenarios then random traffic, all checked
// against a queue-based reference model of the writeback stage.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif
`ifndef ADD
`define ADD 5'd0
`endif
`ifndef SUB
`define SUB 5'd1
`endif
`ifndef CMP
`define CMP 5'd2
`endif

module tb_alu_wb_stage;

    localparam int DW = 16;
    localparam int RW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    opcode;
    logic [RW-1:0] rd;
    logic [DW-1:0] alu_c;
    logic          alu_overflow;
    logic [1:0]    alu_comp_flag;
    logic          trap_en;
    logic          flag_clr;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_rd;
    logic [DW-1:0] out_data;
    logic          cmp_eq, cmp_gt, ovf_sticky, ovf_trap;

    alu_wb_stage #(.DATA_W(DW), .RD_W(RW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rd(rd), .alu_c(alu_c), .alu_overflow(alu_overflow),
        .alu_comp_flag(alu_comp_flag), .trap_en(trap_en), .flag_clr(flag_clr),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_data(out_data), .cmp_eq(cmp_eq), .cmp_gt(cmp_gt),
        .ovf_sticky(ovf_sticky), .ovf_trap(ovf_trap)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pending writebacks in acceptance order plus flag state.
    logic [RW+DW-1:0] mq[$];
    logic m_eq = 1'b0, m_gt = 1'b0, m_stk = 1'b0, m_trap = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check combinational outputs, drive, advance the model, clock, check flags.
    task automatic cyc(input logic v, input logic [4:0] op, input logic [RW-1:0] r,
                       input logic [DW-1:0] c, input logic ov, input logic [1:0] cf,
                       input logic te, input logic fc, input logic ordy, input logic rs);
        logic acc, pop, addsub;
        in_valid = v; opcode = op; rd = r; alu_c = c; alu_overflow = ov;
        alu_comp_flag = cf; trap_en = te; flag_clr = fc; out_ready = ordy; rst = rs;
        #1;
        if (!rs) begin
            check("in_ready", 32'(in_ready), 32'(mq.size() < 2));
            check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
            if (mq.size() > 0) begin
                check("out_rd", 32'(out_rd), 32'(mq[0][RW+DW-1:DW]));
                check("out_data", 32'(out_data), 32'(mq[0][DW-1:0]));
            end
        end
        if (rs) begin
            mq.delete();
            m_eq = 0; m_gt = 0; m_stk = 0; m_trap = 0;
        end else begin
            acc = v && (mq.size() < 2);
            pop = ordy && (mq.size() > 0);
            addsub = acc && (op == `ADD || op == `SUB);
            if (pop) void'(mq.pop_front());
            m_trap = addsub && ov && te;
            if (addsub && !(ov && te)) mq.push_back({r, c});
            if (acc && op == `CMP) begin
                m_eq = cf[0];
                m_gt = cf[1];
            end
            if (addsub && ov) m_stk = 1'b1;
            else if (fc) m_stk = 1'b0;
        end
        @(posedge clk);
        #1;
        check("cmp_eq", 32'(cmp_eq), 32'(m_eq));
        check("cmp_gt", 32'(cmp_gt), 32'(m_gt));
        check("ovf_sticky", 32'(ovf_sticky), 32'(m_stk));
        check("ovf_trap", 32'(ovf_trap), 32'(m_trap));
    endtask

    task automatic idle(input logic ordy);
        cyc(1'b0, 5'd31, '0, '0, 1'bx, 2'bxx, 1'b0, 1'b0, ordy, 1'b0);
    endtask

    initial begin
        logic [4:0] rop;
        logic       rv;
        @(posedge clk);
        #1;
        cyc(0, 5'd31, 0, 0, 0, 0, 0, 0, 1, 1);
        cyc(0, 5'd31, 0, 0, 0, 0, 0, 0, 1, 1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // Basic writeback
        cyc(1, `ADD, 3'd2, 16'h0005, 0, 2'bxx, 0, 0, 1, 0);
        check("basic_out_data", 32'(out_data), 32'h0005);
        idle(1);

        // Backpressure and ordering
        cyc(1, `ADD, 3'd1, 16'h0011, 0, 2'bxx, 0, 0, 0, 0);
        cyc(1, `SUB, 3'd2, 16'h0022, 0, 2'bxx, 0, 0, 0, 0);
        check("bp_full_in_ready", 32'(in_ready), 32'd0);
        cyc(1, `ADD, 3'd3, 16'h0033, 0, 2'bxx, 0, 0, 0, 0);
        cyc(1, `CMP, 3'd0, 16'h0000, 1'bx, 2'b11, 0, 0, 0, 0);
        idle(1);
        idle(1);
        idle(1);

        // Compare flags
        cyc(1, `CMP, 3'd0, 16'h0, 1'bx, 2'b10, 0, 0, 1, 0);
        check("cmp_no_push", 32'(out_valid), 32'd0);
        cyc(1, `CMP, 3'd0, 16'h0, 1'bx, 2'b01, 0, 0, 1, 0);

        // Overflow trap, then the same op untrapped
        cyc(1, `ADD, 3'd4, 16'h8000, 1, 2'bxx, 1, 0, 1, 0);
        check("trap_pulse", 32'(ovf_trap), 32'd1);
        check("trap_no_push", 32'(out_valid), 32'd0);
        idle(1);
        check("trap_one_cycle", 32'(ovf_trap), 32'd0);
        cyc(1, `ADD, 3'd4, 16'h8000, 1, 2'bxx, 0, 0, 1, 0);
        idle(1);

        // Clear versus set
        cyc(0, 5'd31, 0, 0, 1'bx, 2'bxx, 0, 1, 1, 0);
        check("clr_alone", 32'(ovf_sticky), 32'd0);
        cyc(1, `SUB, 3'd5, 16'h7fff, 1, 2'bxx, 0, 1, 1, 0);
        check("set_beats_clr", 32'(ovf_sticky), 32'd1);
        idle(1);

        // Reset mid-stream with a full FIFO and flags set
        cyc(1, `CMP, 3'd0, 16'h0, 1'bx, 2'b11, 0, 0, 0, 0);
        cyc(1, `ADD, 3'd6, 16'h1234, 1, 2'bxx, 0, 0, 0, 0);
        cyc(1, `SUB, 3'd7, 16'h5678, 0, 2'bxx, 0, 0, 0, 0);
        cyc(1, `ADD, 3'd1, 16'h9999, 1, 2'bxx, 1, 0, 0, 1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Unknown qualifiers on other opcodes must leave state untouched
        cyc(1, `CMP, 3'd0, 16'h0, 1'bx, 2'b10, 0, 0, 1, 0);
        cyc(1, `ADD, 3'd2, 16'hbeef, 1, 2'bxx, 0, 0, 0, 0);
        cyc(1, 5'd7, 3'd3, 16'hxxxx, 1'bx, 2'bxx, 1, 0, 0, 0);
        idle(1);
        idle(1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0: rop = `ADD;
                1: rop = `SUB;
                2: rop = `CMP;
                default: rop = 5'($urandom_range(3, 31));
            endcase
            rv = ($urandom_range(0, 3) != 0);
            cyc(rv, rop, 3'($urandom), 16'($urandom),
                (rop == `ADD || rop == `SUB) ? ($urandom_range(0, 4) == 0) : 1'bx,
                (rop == `CMP) ? 2'($urandom) : 2'bxx,
                1'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 99) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_wb_stage.md
# alu_wb_stage

Execute-to-writeback stage directly downstream of the ALU. It registers each ALU result together with its destination register index, and buffers it in a 2-entry FIFO toward the register-file write port using a valid/ready handshake. It also maintains the architectural compare flags (from `CMP`) and a sticky overflow flag (from `ADD`/`SUB`), with an optional overflow trap that suppresses writeback.

## Interface
Parameters:
- DATA_W, default `` `WORD_SIZE ``: width of ALU result and writeback data.
- RD_W, default 3: destination register index width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  an ALU operation is presented this cycle.
- in_ready  out  1  stage can accept; equals (count < 2).
- opcode  in  5  opcode driven to the ALU this cycle.
- rd  in  RD_W  destination register index.
- alu_c  in  DATA_W  ALU result `c`.
- alu_overflow  in  1  ALU overflow.
- alu_comp_flag  in  2  ALU compare flags: [0] = equal, [1] = greater.
- trap_en  in  1  when 1, an overflowing `ADD`/`SUB` is not written back.
- flag_clr  in  1  clears sticky overflow.
- out_valid  out  1  FIFO head holds a writeback entry.
- out_ready  in  1  register-file write port accepts the head.
- out_rd  out  RD_W  head destination index.
- out_data  out  DATA_W  head result.
- cmp_eq, cmp_gt  out  1 each  registered compare flags.
- ovf_sticky  out  1  sticky overflow flag.
- ovf_trap  out  1  one-cycle pulse on a trapped overflow.

## Operation
- Accept: `acc = in_valid & in_ready`. Transfer: `pop = out_valid & out_ready`.
- An accepted opcode is classified as follows:
  - `` `ADD ``/`` `SUB ``:
    - If `alu_overflow & trap_en`: no push; `ovf_trap` pulses.
    - Otherwise push `{rd, alu_c}`.
    - `ovf_sticky` is set whenever `alu_overflow` = 1, regardless of `trap_en`.
  - `` `CMP ``: `cmp_eq <= alu_comp_flag[0]`, `cmp_gt <= alu_comp_flag[1]`; no push; overflow is ignored.
  - Any other opcode: consumed and dropped; no flag change.
- `alu_overflow` is X outside `ADD`/`SUB` and `alu_comp_flag` is X outside `CMP`. Both must be qualified by opcode, so X never propagates into state.
- FIFO:
  - 2 entries, circular write/read pointers, `count` 0..2.
  - Head is presented at `out_*` whenever count > 0.
  - Push and pop in the same cycle leave count unchanged.
  - Entries leave in acceptance order.
- `in_ready` depends only on `count`, never on `opcode`. A full FIFO therefore stalls `CMP` too, which preserves flag/writeback ordering.
- `in_ready` does not depend on `out_ready` in the same cycle, so there is no combinational ready path from the register file to the ALU.
- `flag_clr` and a setting overflow in the same cycle: set wins (`ovf_sticky` = 1).
- `out_data`/`out_rd` hold stable while `out_valid & ~out_ready`.

## Timing
- Reset (synchronous): count = 0, pointers = 0, `out_valid` = 0, `cmp_eq` = `cmp_gt` = 0, `ovf_sticky` = 0, `ovf_trap` = 0, `in_ready` = 1 from the first cycle after reset. `out_data`/`out_rd` are don't-care while `out_valid` = 0.
- Accept at edge N → entry visible on `out_valid`/`out_data` in cycle N+1. Minimum latency is 1 cycle.
- Flags and `ovf_sticky` update at the edge that accepts the op; they are visible in cycle N+1.
- `ovf_trap` is high for exactly cycle N+1, then returns to 0 unless another trap is accepted.
- Throughput: 1 op/cycle while `out_ready` stays high.
- Backpressure: with `out_ready` = 0, two pushes fill the FIFO and `in_ready` drops in the following cycle. The first pop re-raises `in_ready` in the cycle after the pop.
- `rst` asserted mid-operation discards FIFO contents and clears all flags at that edge; in-flight `in_valid` is ignored.

## Test plan
- Basic writeback (DATA_W = 16): `ADD`, rd = 2, `alu_c` = 0x0005, `out_ready` = 1 → next cycle `out_valid` = 1, `out_rd` = 2, `out_data` = 0x0005; `ovf_sticky` = 0.
- Backpressure/ordering: `out_ready` = 0; accept `ADD` rd1 = 0x0011 and `SUB` rd2 = 0x0022 → `in_ready` = 0; third op held. Raise `out_ready` → 0x0011 then 0x0022 on consecutive cycles; `in_ready` returns to 1.
- Compare: `CMP` with `alu_comp_flag` = 2'b10 → `cmp_gt` = 1, `cmp_eq` = 0, no `out_valid`. Then `CMP` with 2'b01 → `cmp_eq` = 1, `cmp_gt` = 0.
- Overflow trap: `trap_en` = 1, `ADD` with `alu_overflow` = 1, `alu_c` = 0x8000 → no push, `ovf_trap` = 1 for one cycle, `ovf_sticky` = 1. With `trap_en` = 0 the same op pushes 0x8000 and sets sticky.
- Clear vs set: hold `ovf_sticky` = 1; `flag_clr` = 1 alone → 0. Then `flag_clr` = 1 with an accepted overflowing `SUB` → stays 1.
- Reset mid-stream: FIFO holds 2 entries, flags set; pulse `rst` → next cycle `out_valid` = 0, all flags 0, `in_ready` = 1. X on `alu_overflow`/`alu_comp_flag` with opcode not `ADD`/`SUB`/`CMP` leaves all state unchanged.
